serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor and the sequential successor to the single-bit half adder. It takes two WIDTH-bit operands through a start/done handshake and processes one bit per clock, LSB first, with a single carry flip-flop. It reports sum, carry/no-borrow and signed overflow. It sits beside the combinational adder cells as the area-minimal option for wide operands.

---
 rtl/serial_adder.sv | 137 +++++++++++++
 tb/tb_serial_adder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder/subtractor. It handles one bit per clock, LSB first,
//   using a single carry flop. Operands are captured on start while IDLE.
//   The result, carry/no-borrow and signed overflow are registered on the
//   edge that enters DONE, and they hold until the next result.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, accepted only in IDLE
//   sub        0 = a+b, 1 = a-b (sampled with start)
//   a, b       WIDTH-bit operands (sampled with start)
//   busy       high in RUN and DONE
//   done       one-cycle result-valid pulse
//   sum        registered result
//   carry_out  add: carry out of MSB; sub: 1 = no borrow
//   overflow   signed two's-complement overflow
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic               bit_s, bit_c;
    logic [WIDTH-1:0]   res_shift;

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        bit_s = opa_q[0] ^ opb_q[0] ^ carry_q;
        bit_c = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);

        // The new sum bit enters at the MSB. After WIDTH shifts, bit 0 lands at LSB.
        res_shift            = res_q >> 1;
        res_shift[WIDTH-1]   = bit_s;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1. The +1 is the initial carry.
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                res_d   = res_shift;
                carry_d = bit_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    // The MSB bit is processed in this cycle. carry_q is the
                    // carry into the MSB, and bit_c is the carry out of it.
                    sum_d   = res_shift;
                    cout_d  = bit_c;
                    ovf_d   = carry_q ^ bit_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [63:0] a_in = '0;
    logic [63:0] b_in = '0;

    always #5 clk = ~clk;

    logic        d1_busy, d1_done, d1_cout, d1_ovf;
    logic [0:0]  d1_sum;
    logic        d8_busy, d8_done, d8_cout, d8_ovf;
    logic [7:0]  d8_sum;
    logic        d13_busy, d13_done, d13_cout, d13_ovf;
    logic [12:0] d13_sum;
    logic        d64_busy, d64_done, d64_cout, d64_ovf;
    logic [63:0] d64_sum;

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .a(a_in[0:0]), .b(b_in[0:0]), .busy(d1_busy), .done(d1_done),
        .sum(d1_sum), .carry_out(d1_cout), .overflow(d1_ovf));
    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .a(a_in[7:0]), .b(b_in[7:0]), .busy(d8_busy), .done(d8_done),
        .sum(d8_sum), .carry_out(d8_cout), .overflow(d8_ovf));
    serial_adder #(.WIDTH(13)) dut13 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .a(a_in[12:0]), .b(b_in[12:0]), .busy(d13_busy), .done(d13_done),
        .sum(d13_sum), .carry_out(d13_cout), .overflow(d13_ovf));
    serial_adder #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .a(a_in), .b(b_in), .busy(d64_busy), .done(d64_done),
        .sum(d64_sum), .carry_out(d64_cout), .overflow(d64_ovf));

    int checks = 0;
    int errors = 0;

    // Captured results are packed as {overflow, carry_out, zero-extended sum}.
    logic [65:0] r1, r8, r13, r64;
    int          n1, n8, n13, n64;

    typedef struct {
        int          w;
        logic        sub;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: signed overflow is derived from operand and result
    // signs, not from carries.
    function automatic logic [65:0] model(input int w, input logic s,
                                          input logic [63:0] av, input logic [63:0] bv);
        logic [64:0] mask, full;
        logic [63:0] aa, bb, r;
        logic        co, ov;
        mask = (65'd1 << w) - 65'd1;
        aa   = av & mask[63:0];
        bb   = (s ? ~bv : bv) & mask[63:0];
        full = {1'b0, aa} + {1'b0, bb} + {64'd0, s};
        r    = full[63:0] & mask[63:0];
        co   = full[w];
        ov   = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
        return {ov, co, r};
    endfunction

    // Issue one operation to all four instances and collect each done pulse.
    // The call is made away from a clock edge and leaves all instances idle.
    task automatic run_op(input logic s, input logic [63:0] av, input logic [63:0] bv);
        n1 = 0; n8 = 0; n13 = 0; n64 = 0;
        start = 1'b1; sub = s; a_in = av; b_in = bv;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk); #1;
            if (d1_done)  begin n1++;  r1  = {d1_ovf,  d1_cout,  64'(d1_sum)};  end
            if (d8_done)  begin n8++;  r8  = {d8_ovf,  d8_cout,  64'(d8_sum)};  end
            if (d13_done) begin n13++; r13 = {d13_ovf, d13_cout, 64'(d13_sum)}; end
            if (d64_done) begin n64++; r64 = {d64_ovf, d64_cout, d64_sum};      end
        end
    endtask

    initial begin
        int          busy_cnt, done_cnt, done_at, dn, stable_bad, stray;
        logic [7:0]  last_sum, ea, eb;
        logic [65:0] got;
        logic [63:0] ra, rb;
        logic        rs;

        vecs[0]  = '{8, 1'b0, 64'h0F, 64'h01, 64'h10, 1'b0, 1'b0};
        vecs[1]  = '{8, 1'b0, 64'hFF, 64'h01, 64'h00, 1'b1, 1'b0};
        vecs[2]  = '{8, 1'b0, 64'h7F, 64'h01, 64'h80, 1'b0, 1'b1};
        vecs[3]  = '{8, 1'b1, 64'h05, 64'h07, 64'hFE, 1'b0, 1'b0};
        vecs[4]  = '{8, 1'b1, 64'h80, 64'h01, 64'h7F, 1'b1, 1'b1};
        vecs[5]  = '{8, 1'b1, 64'h07, 64'h07, 64'h00, 1'b1, 1'b0};
        vecs[6]  = '{8, 1'b0, 64'h80, 64'h80, 64'h00, 1'b1, 1'b1};
        vecs[7]  = '{1, 1'b0, 64'h0,  64'h0,  64'h0,  1'b0, 1'b0};
        vecs[8]  = '{1, 1'b0, 64'h0,  64'h1,  64'h1,  1'b0, 1'b0};
        vecs[9]  = '{1, 1'b0, 64'h1,  64'h0,  64'h1,  1'b0, 1'b0};
        vecs[10] = '{1, 1'b0, 64'h1,  64'h1,  64'h0,  1'b1, 1'b1};

        // Reset state
        #1;
        chk("rst_busy", 66'(d8_busy), 66'd0);
        chk("rst_done", 66'(d8_done), 66'd0);
        chk("rst_out", {d8_ovf, d8_cout, 64'(d8_sum)}, 66'd0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].sub, vecs[i].a, vecs[i].b);
            if (vecs[i].w == 1) begin
                chk($sformatf("v%0d_ndone", i), 66'(n1), 66'd1);
                got = r1;
            end else begin
                chk($sformatf("v%0d_ndone", i), 66'(n8), 66'd1);
                got = r8;
            end
            chk($sformatf("v%0d_sum", i),  66'(got[63:0]), 66'(vecs[i].sum));
            chk($sformatf("v%0d_cout", i), 66'(got[64]),   66'(vecs[i].cout));
            chk($sformatf("v%0d_ovf", i),  66'(got[65]),   66'(vecs[i].ovf));
        end

        // Handshake timing: 0x0F + 0x01 on WIDTH=8. Cycle 1 is the first
        // cycle after the start edge.
        start = 1'b1; sub = 1'b0; a_in = 64'h0F; b_in = 64'h01;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int c = 1; c <= 12; c++) begin
            if (d8_busy) busy_cnt++;
            if (d8_done) begin done_cnt++; done_at = c; end
            @(posedge clk); #1;
        end
        chk("lat_busy_cycles", 66'(busy_cnt), 66'd9);
        chk("lat_done_cycle", 66'(done_at), 66'd9);
        chk("lat_done_pulses", 66'(done_cnt), 66'd1);
        chk("lat_sum", 66'(d8_sum), 66'h10);
        repeat (70) @(posedge clk);
        #1;

        // Start held high with operands changing every cycle. Only the
        // operands present at edges 0, 10 and 20 are accepted.
        dn = 0; stable_bad = 0; last_sum = '0;
        for (int i = 0; i < 30; i++) begin
            start = 1'b1; sub = 1'b0;
            a_in = 64'(i * 3 + 1); b_in = 64'(i * 5 + 2);
            @(posedge clk); #1;
            if (d8_done) begin
                ea = 8'((10 * dn) * 3 + 1);
                eb = 8'((10 * dn) * 5 + 2);
                chk($sformatf("hold_edge%0d", dn), 66'(i), 66'(8 + 10 * dn));
                chk($sformatf("hold_sum%0d", dn), 66'(d8_sum), 66'(ea + eb));
                last_sum = d8_sum;
                dn++;
            end else if (dn > 0 && d8_sum != last_sum) begin
                stable_bad++;
            end
        end
        start = 1'b0;
        chk("hold_ndone", 66'(dn), 66'd3);
        chk("hold_stable", 66'(stable_bad), 66'd0);
        repeat (80) @(posedge clk);
        #1;

        // Reset during the 4th RUN cycle
        start = 1'b1; sub = 1'b0; a_in = 64'h55; b_in = 64'h22;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 66'(d8_busy), 66'd0);
        chk("mid_rst_done", 66'(d8_done), 66'd0);
        chk("mid_rst_sum", 66'(d8_sum), 66'd0);
        chk("mid_rst_cout", 66'(d8_cout), 66'd0);
        chk("mid_rst_ovf", 66'(d8_ovf), 66'd0);
        @(negedge clk) rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (d8_done || d8_busy) stray++;
        end
        chk("mid_rst_no_done", 66'(stray), 66'd0);
        run_op(1'b0, 64'h12, 64'h34);
        chk("post_rst_sum", 66'(r8[63:0]), 66'h46);

        // Random operations compared against the model at every width
        for (int t = 0; t < 16; t++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            rs = 1'($urandom_range(0, 1));
            run_op(rs, ra, rb);
            chk($sformatf("rnd%0d_n", t), {n1[15:0], n8[15:0], n13[15:0], n64[15:0]},
                66'h0001_0001_0001_0001);
            chk($sformatf("rnd%0d_w1", t),  r1,  model(1, rs, ra, rb));
            chk($sformatf("rnd%0d_w8", t),  r8,  model(8, rs, ra, rb));
            chk($sformatf("rnd%0d_w13", t), r13, model(13, rs, ra, rb));
            chk($sformatf("rnd%0d_w64", t), r64, model(64, rs, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
